// File: rtl/nanocache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nanocache_pkg
// Purpose  : Shared types and constants for the nanocache miss arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package nanocache_pkg;

  localparam int LINE_W   = 256;
  localparam int MAX_PORT = 4;
  localparam int PTR_W    = $clog2(MAX_PORT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_RD = 2'd0,
    OP_WR = 2'd1,
    OP_WB = 2'd2
  } op_e;

endpackage
`default_nettype wire

// File: rtl/nanocache_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : nanocache_rr_pick
// Purpose  : Combinational round-robin picker; first requester at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module nanocache_rr_pick
  import nanocache_pkg::*;
#(
  parameter int NUM_PORT = 2
) (
  input  logic [NUM_PORT-1:0] i_req,
  input  logic [PTR_W-1:0]    i_ptr,
  output logic [NUM_PORT-1:0] o_gnt,
  output logic                o_valid
);

  logic [2*NUM_PORT-1:0] w_dbl;
  logic [2*NUM_PORT-1:0] w_gnt_dbl;
  logic [NUM_PORT-1:0]   w_rot;
  logic [NUM_PORT-1:0]   w_rot_gnt;

  // Rotate so ptr lands at bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    w_dbl     = {i_req, i_req} >> i_ptr;
    w_rot     = w_dbl[NUM_PORT-1:0];
    w_rot_gnt = w_rot & (~w_rot + NUM_PORT'(1));
    w_gnt_dbl = {w_rot_gnt, w_rot_gnt} << i_ptr;
    o_gnt     = w_gnt_dbl[2*NUM_PORT-1:NUM_PORT];
    o_valid   = |i_req;
  end

endmodule
`default_nettype wire

// File: rtl/nanocache_miss_arb.sv
`default_nettype none
// ============================================================================
// Module   : nanocache_miss_arb
// Purpose  : Arbitrates per-port cache miss/write-back traffic onto one SRAM port.
// Revision : 1.0 - initial release
// ============================================================================
module nanocache_miss_arb #(
  parameter int NUM_PORT = 2,
  parameter int LINE_W   = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_PORT-1:0]          i_miss_rden,
  input  logic [NUM_PORT-1:0]          i_miss_wren,
  input  logic [NUM_PORT-1:0]          i_wb_wren,
  input  logic [NUM_PORT*32-1:0]       i_miss_addr,
  input  logic [NUM_PORT*LINE_W-1:0]   i_miss_wdata,
  output logic [NUM_PORT-1:0]          o_miss_resp,
  output logic [NUM_PORT-1:0]          o_wb_gnt,
  output logic [NUM_PORT-1:0]          o_upd_valid,
  output logic [LINE_W-1:0]            o_upd_rdata,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [31:0]                  o_mem_addr,
  output logic [LINE_W-1:0]            o_mem_wdata,
  input  logic                         i_mem_gnt,
  input  logic                         i_mem_rvalid,
  input  logic [LINE_W-1:0]            i_mem_rdata
);
  import nanocache_pkg::*;

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [PTR_W-1:0]      id_q;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [31:0]           addr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     upd_rdata_q;
  logic [NUM_PORT-1:0]   resp_q, wb_gnt_q, upd_valid_q;

  logic [NUM_PORT-1:0]   w_demand, w_req_vec, w_gnt;
  logic                  w_pick_valid, w_use_demand;
  logic [PTR_W-1:0]      w_win, w_next_ptr;
  logic [31:0]           w_sel_addr;
  logic [LINE_W-1:0]     w_sel_wdata;
  op_e                   w_op;
  logic [NUM_PORT-1:0]   w_id_oh;

  // Write-backs only compete when no demand request is pending anywhere.
  assign w_demand     = i_miss_rden | i_miss_wren;
  assign w_use_demand = |w_demand;
  assign w_req_vec    = w_use_demand ? w_demand : i_wb_wren;

  nanocache_rr_pick #(.NUM_PORT(NUM_PORT)) u_pick (
    .i_req   (w_req_vec),
    .i_ptr   (rr_ptr_q),
    .o_gnt   (w_gnt),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_win       = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (w_gnt[p]) begin
        w_win       = PTR_W'(p);
        w_sel_addr  = i_miss_addr[p*32 +: 32];
        w_sel_wdata = i_miss_wdata[p*LINE_W +: LINE_W];
      end
    end
  end

  assign w_next_ptr = (w_win == PTR_W'(NUM_PORT-1)) ? '0 : w_win + PTR_W'(1);
  assign w_op       = !w_use_demand ? OP_WB :
                      (|(i_miss_wren & w_gnt)) ? OP_WR : OP_RD;
  assign w_id_oh    = NUM_PORT'(1) << id_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (w_pick_valid) state_d = ST_ISSUE;
      ST_ISSUE:   if (i_mem_gnt) state_d = (op_q == OP_RD) ? ST_WAIT_RD : ST_DONE;
      ST_WAIT_RD: if (i_mem_rvalid) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state_q == ST_ISSUE) begin
      o_mem_req   = 1'b1;
      o_mem_we    = (op_q != OP_RD);
      o_mem_addr  = addr_q;
      o_mem_wdata = wdata_q;
    end
  end

  // Command latch and response pulses; latched work completes regardless of requester.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q        <= OP_RD;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      upd_rdata_q <= '0;
      resp_q      <= '0;
      wb_gnt_q    <= '0;
      upd_valid_q <= '0;
    end else begin
      resp_q      <= '0;
      wb_gnt_q    <= '0;
      upd_valid_q <= '0;
      if (state_q == ST_IDLE && w_pick_valid) begin
        id_q     <= w_win;
        op_q     <= w_op;
        addr_q   <= w_sel_addr;
        wdata_q  <= w_sel_wdata;
        rr_ptr_q <= w_next_ptr;
      end
      if (state_q == ST_ISSUE && i_mem_gnt) begin
        if (op_q == OP_WB) wb_gnt_q <= w_id_oh;
        else               resp_q   <= w_id_oh;
      end
      if (state_q == ST_WAIT_RD && i_mem_rvalid) begin
        upd_rdata_q <= i_mem_rdata;
        upd_valid_q <= w_id_oh;
      end
    end
  end

  assign o_miss_resp = resp_q;
  assign o_wb_gnt    = wb_gnt_q;
  assign o_upd_valid = upd_valid_q;
  assign o_upd_rdata = upd_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_nanocache_miss_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_nanocache_miss_arb
// Purpose  : Self-checking bench for nanocache_miss_arb against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nanocache_miss_arb;
  localparam int NP = 2;
  localparam int LW = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     rden, wren, wbw;
  logic [NP*32-1:0]  addr;
  logic [NP*LW-1:0]  wdata;
  logic [NP-1:0]     resp, wbg, updv;
  logic [LW-1:0]     updd;
  logic              mreq, mwe, mgnt, mrv;
  logic [31:0]       maddr;
  logic [LW-1:0]     mwdata, mrd;

  always #5 clk = ~clk;

  nanocache_miss_arb #(.NUM_PORT(NP), .LINE_W(LW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_miss_rden(rden), .i_miss_wren(wren), .i_wb_wren(wbw),
    .i_miss_addr(addr), .i_miss_wdata(wdata),
    .o_miss_resp(resp), .o_wb_gnt(wbg), .o_upd_valid(updv), .o_upd_rdata(updd),
    .o_mem_req(mreq), .o_mem_we(mwe), .o_mem_addr(maddr), .o_mem_wdata(mwdata),
    .i_mem_gnt(mgnt), .i_mem_rvalid(mrv), .i_mem_rdata(mrd)
  );

  int n_pass = 0, n_total = 0;

  // Transaction model: one record in flight, stage 0 = awaiting grant,
  // 1 = awaiting read data, 2 = completion cycle.
  bit            m_busy;
  int            m_stage, m_id, m_op, m_rr;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_wdata, m_rdata;
  logic [NP-1:0] m_resp, m_wbg, m_upd;

  int            gnt_pct = 100, rd_cnt = 0, rd_lo = 1, rd_hi = 1;
  logic [NP-1:0] sticky_rd = '0;
  bit            prev_req = 1'b0, new_txn = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tmo(input string nm);
    n_total++;
    $display("FAIL %s actual=no-event required=event", nm);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_stage = 0; m_id = 0; m_op = 0; m_rr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_resp = '0; m_wbg = '0; m_upd = '0;
  endtask

  task automatic model_step();
    logic [NP-1:0] dem, vec;
    int p;
    m_resp = '0; m_wbg = '0; m_upd = '0;
    if (rst) begin model_reset(); return; end
    if (!m_busy) begin
      dem = rden | wren;
      vec = (dem != '0) ? dem : wbw;
      if (vec != '0) begin
        p = 0;
        for (int off = 0; off < NP; off++) begin
          p = (m_rr + off) % NP;
          if (vec[p]) break;
        end
        m_id    = p;
        m_op    = (dem == '0) ? 2 : (wren[p] ? 1 : 0);
        m_addr  = addr[p*32 +: 32];
        m_wdata = wdata[p*LW +: LW];
        m_rr    = (p + 1) % NP;
        m_busy  = 1;
        m_stage = 0;
      end
    end else if (m_stage == 0) begin
      if (mgnt) begin
        if (m_op == 2) m_wbg[m_id] = 1'b1;
        else           m_resp[m_id] = 1'b1;
        m_stage = (m_op == 0) ? 1 : 2;
      end
    end else if (m_stage == 1) begin
      if (mrv) begin
        m_rdata = mrd;
        m_upd[m_id] = 1'b1;
        m_stage = 2;
      end
    end else begin
      m_busy = 0;
    end
  endtask

  task automatic check_all();
    bit er;
    er = m_busy && (m_stage == 0);
    chk("mem_req",   LW'(mreq),   LW'(er));
    chk("mem_we",    LW'(mwe),    LW'(er && (m_op != 0)));
    chk("mem_addr",  LW'(maddr),  er ? LW'(m_addr) : '0);
    chk("mem_wdata", mwdata,      er ? m_wdata : '0);
    chk("miss_resp", LW'(resp),   LW'(m_resp));
    chk("wb_gnt",    LW'(wbg),    LW'(m_wbg));
    chk("upd_valid", LW'(updv),   LW'(m_upd));
    chk("upd_rdata", updd,        m_rdata);
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_step();
    check_all();
    new_txn  = mreq && !prev_req;
    prev_req = mreq;
  endtask

  // Requesters drop on their response; memory grants/returns data.
  task automatic drive_auto(input bit gen);
    for (int p = 0; p < NP; p++) begin
      if (resp[p]) begin
        if (wren[p]) begin
          wren[p] = 1'b0;
          addr[p*32 +: 32] = addr[p*32 +: 32] ^ 32'h100;
        end else rden[p] = 1'b0;
      end
      if (wbg[p]) wbw[p] = 1'b0;
      if (gen && $urandom_range(0, 63) == 0) begin
        rden[p] = 1'b0; wren[p] = 1'b0; wbw[p] = 1'b0;
      end
      if (gen && !rden[p] && !wren[p] && !wbw[p] && $urandom_range(0, 3) == 0) begin
        addr[p*32 +: 32]  = $urandom;
        wdata[p*LW +: LW] = rand_line();
        case ($urandom_range(0, 3))
          0:       rden[p] = 1'b1;
          1:       wren[p] = 1'b1;
          2:       begin wren[p] = 1'b1; rden[p] = 1'b1; end
          default: wbw[p] = 1'b1;
        endcase
      end
    end
    rden = rden | sticky_rd;
    mrv = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin mrv = 1'b1; mrd = rand_line(); end
    end
    if (mreq && $urandom_range(0, 99) < gnt_pct) begin
      mgnt = 1'b1;
      if (!mwe) rd_cnt = $urandom_range(rd_lo, rd_hi);
    end else mgnt = 1'b0;
  endtask

  task automatic drain(input int n, input bit gen);
    for (int i = 0; i < n; i++) begin step(); drive_auto(gen); end
  endtask

  task automatic wait_txn(input string nm, input bit gen);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      step(); drive_auto(gen);
      if (new_txn) begin ok = 1; break; end
    end
    if (!ok) tmo(nm);
  endtask

  task automatic do_reset();
    rst = 1'b1; rden = '0; wren = '0; wbw = '0;
    mgnt = 1'b0; mrv = 1'b0; rd_cnt = 0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; rden = '0; wren = '0; wbw = '0; addr = '0; wdata = '0;
    mgnt = 1'b0; mrv = 1'b0; mrd = '0;
    model_reset();
    step(); step();
    chk("rst_req", LW'(mreq), '0);
    chk("rst_rdata", updd, '0);

    // Single demand read with immediate grant and 1-cycle return.
    rst = 1'b0;
    rden = 2'b01; addr[31:0] = 32'h100;
    step();
    chk("rd_req", LW'(mreq), LW'(1));
    chk("rd_addr", LW'(maddr), LW'(32'h100));
    mgnt = 1'b1;
    step();
    chk("rd_resp", LW'(resp), LW'(2'b01));
    mgnt = 1'b0; rden = '0; mrv = 1'b1; mrd = {32{8'hA5}};
    step();
    chk("rd_upd", LW'(updv), LW'(2'b01));
    chk("rd_data", updd, {32{8'hA5}});
    chk("rd_nowb", LW'(wbg), '0);
    mrv = 1'b0;
    step(); step();

    // Simultaneous reads after reset; port0 keeps re-requesting.
    do_reset();
    addr = {32'h300, 32'h200}; rden = 2'b11; sticky_rd = 2'b01;
    wait_txn("rr_first", 0);  chk("rr_first",  LW'(maddr), LW'(32'h200));
    wait_txn("rr_second", 0); chk("rr_second", LW'(maddr), LW'(32'h300));
    wait_txn("rr_third", 0);  chk("rr_third",  LW'(maddr), LW'(32'h200));
    sticky_rd = '0;
    drain(20, 0);

    // Demand write beats background write-back.
    addr = {32'h500, 32'h400}; wdata = {rand_line(), rand_line()};
    wren = 2'b01; wbw = 2'b10;
    wait_txn("wr_first", 0);
    chk("wr_we", LW'(mwe), LW'(1));
    chk("wr_addr", LW'(maddr), LW'(32'h400));
    wait_txn("wb_second", 0);
    chk("wb_we", LW'(mwe), LW'(1));
    chk("wb_addr", LW'(maddr), LW'(32'h500));
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(); if (wbg == 2'b10) seen = 1; drive_auto(0);
    end
    chk("wb_gnt1", LW'(seen), LW'(1));
    drain(10, 0);

    // Dirty-victim flow: write then fill on the same port.
    addr[31:0] = 32'h600; wren = 2'b01; rden = 2'b01;
    wait_txn("victim_wr", 0);
    chk("victim_we", LW'(mwe), LW'(1));
    chk("victim_addr", LW'(maddr), LW'(32'h600));
    wait_txn("fill_rd", 0);
    chk("fill_we", LW'(mwe), '0);
    chk("fill_addr", LW'(maddr), LW'(32'h700));
    drain(10, 0);

    // Grant withheld for 10 cycles.
    gnt_pct = 0;
    addr[63:32] = 32'h800; rden = 2'b10;
    wait_txn("stall", 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", LW'(mreq), LW'(1));
      chk("stall_addr", LW'(maddr), LW'(32'h800));
      step(); drive_auto(0);
    end
    gnt_pct = 100;
    drain(10, 0);

    // Reset while waiting for read data; late data must be ignored.
    rd_lo = 3; rd_hi = 3;
    addr[31:0] = 32'h900; rden = 2'b01;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(); drive_auto(0);
      if (resp[0]) seen = 1;
    end
    if (!seen) tmo("rst_wait_rd");
    rst = 1'b1; rden = '0; rd_cnt = 0; mgnt = 1'b0;
    #1;
    model_reset();
    chk("arst_req", LW'(mreq), '0);
    chk("arst_resp", LW'(resp), '0);
    check_all();
    step();
    rst = 1'b0; mrv = 1'b1; mrd = rand_line();
    step();
    chk("late_rvalid", LW'(updv), '0);
    mrv = 1'b0;
    addr[63:32] = 32'hA00; rden = 2'b10;
    wait_txn("post_rst", 0);
    chk("post_rst_addr", LW'(maddr), LW'(32'hA00));
    drain(10, 0);

    // Randomised traffic.
    rd_lo = 1; rd_hi = 4; gnt_pct = 60;
    drain(3000, 1);
    gnt_pct = 100;
    drain(40, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
